// File: rtl/gen_stream_pkg.sv
// Shared types and constants for the generator drain stage.
// State encoding plus FIFO pointer sizing helper.
package gen_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    DRAIN,
    DONE
  } gen_drain_state_t;

  // One extra MSB distinguishes full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gen_stream_drain_if.sv
// Handshake bundle between host, drain stage and generator.
// slave is the drain stage's view, master the environment's.
interface gen_stream_drain_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);

  logic                    _start;
  logic signed [WIDTH-1:0] arg0;
  logic signed [WIDTH-1:0] arg1;
  logic signed [WIDTH-1:0] arg2;

  logic                    gen_reset;
  logic                    gen_start;
  logic signed [WIDTH-1:0] gen_arg0;
  logic signed [WIDTH-1:0] gen_arg1;
  logic signed [WIDTH-1:0] gen_arg2;
  logic                    gen_ready;
  logic                    gen_valid;
  logic                    gen_done;
  logic signed [WIDTH-1:0] gen_out0;

  logic                    _ready;
  logic                    _valid;
  logic signed [WIDTH-1:0] _out0;
  logic                    _done;
  logic [CNT_W-1:0]        _count;

  modport slave (
    input  _start,
    input  arg0,
    input  arg1,
    input  arg2,
    output gen_reset,
    output gen_start,
    output gen_arg0,
    output gen_arg1,
    output gen_arg2,
    output gen_ready,
    input  gen_valid,
    input  gen_done,
    input  gen_out0,
    input  _ready,
    output _valid,
    output _out0,
    output _done,
    output _count
  );

  modport master (
    output _start,
    output arg0,
    output arg1,
    output arg2,
    input  gen_reset,
    input  gen_start,
    input  gen_arg0,
    input  gen_arg1,
    input  gen_arg2,
    input  gen_ready,
    output gen_valid,
    output gen_done,
    output gen_out0,
    output _ready,
    input  _valid,
    input  _out0,
    input  _done,
    input  _count
  );

endinterface

// File: rtl/gen_stream_fifo.sv
// Small synchronous FIFO, registered head, no fall-through.
// Wrapping pointers carry an extra MSB for full/empty.
module gen_stream_fifo
  import gen_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    wr_d;
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer advance; flush wins over push and pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; flushed pushes are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !flush_i) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0])
                && (wr_q[PW-1] != rd_q[PW-1]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/gen_stream_drain.sv
// Drain stage: launches a generator, buffers its outputs,
// and signals end-of-stream once the buffer has emptied.
module gen_stream_drain
  import gen_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               _clock,
  input  logic               _reset,
  gen_stream_drain_if.slave  bus
);

  gen_drain_state_t state_q;
  gen_drain_state_t state_d;

  logic signed [WIDTH-1:0] arg0_q;
  logic signed [WIDTH-1:0] arg1_q;
  logic signed [WIDTH-1:0] arg2_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic                    gen_reset_q;

  logic             start;
  logic             gen_start;
  logic             gen_ready;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;

  assign start = bus._start;
  assign push  = bus.gen_valid && gen_ready && !start;
  assign pop   = !empty && bus._ready && !start;

  // Next state and generator-side strobes.
  always_comb begin
    state_d   = state_q;
    gen_start = 1'b0;
    gen_ready = 1'b0;
    unique case (state_q)
      IDLE: ;
      LAUNCH: begin
        gen_start = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        gen_ready = !full;
        if (bus.gen_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty) state_d = DONE;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (start) state_d = LAUNCH;
  end

  // Delivered-value counter, saturating, cleared by start.
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (pop && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State, counter and generator reset registers.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      gen_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      gen_reset_q <= 1'b0;
    end
  end

  // Argument latches, loaded on start.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      arg0_q <= '0;
      arg1_q <= '0;
      arg2_q <= '0;
    end else if (start) begin
      arg0_q <= bus.arg0;
      arg1_q <= bus.arg1;
      arg2_q <= bus.arg2;
    end
  end

  gen_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (_clock),
    .rst_ni  (_reset),
    .flush_i (start),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.gen_out0),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

  assign bus.gen_reset = gen_reset_q;
  assign bus.gen_start = gen_start;
  assign bus.gen_arg0  = arg0_q;
  assign bus.gen_arg1  = arg1_q;
  assign bus.gen_arg2  = arg2_q;
  assign bus.gen_ready = gen_ready;
  assign bus._valid    = !empty;
  assign bus._out0     = empty ? '0 : head;
  assign bus._done     = (state_q == DONE);
  assign bus._count    = count_q;

endmodule

// File: tb/tb_gen_stream_drain.sv
// Directed bench for gen_stream_drain with a range
// generator model (start, limit, step) on the far side.
module tb_gen_stream_drain;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gen_stream_drain_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  gen_stream_drain #(
    .WIDTH (W),
    .DEPTH (D),
    .CNT_W (CW)
  ) dut (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  int g_cur  = 0;
  int g_lim  = 0;
  int g_step = 0;
  bit g_act  = 1'b0;
  bit g_mode = 1'b0;

  // Generator model: emits cur, cur+step, ... while < lim.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_act <= 1'b0;
    end else if (bus.gen_reset) begin
      g_act <= 1'b0;
    end else if (bus.gen_start) begin
      g_cur  <= bus.gen_arg0;
      g_lim  <= bus.gen_arg1;
      g_step <= bus.gen_arg2;
      g_act  <= 1'b1;
    end else if (g_act && bus.gen_valid && bus.gen_ready) begin
      g_cur <= g_cur + g_step;
    end
  end

  // In mode 1, done is raised together with the final value.
  always_comb begin
    bus.gen_valid = g_act && (g_cur < g_lim);
    bus.gen_out0  = g_cur;
    bus.gen_done  = g_act && ((g_cur >= g_lim) ||
                    (g_mode && bus.gen_valid && bus.gen_ready &&
                     (g_cur + g_step >= g_lim)));
  end

  int popq[$];
  int ex[$];
  int pushes = 0;
  int starts = 0;
  bit both   = 1'b0;

  // Observe transfers on both sides at the active edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus._valid && bus._ready && !bus._start)
        popq.push_back(bus._out0);
      if (bus.gen_valid && bus.gen_ready && !bus._start)
        pushes++;
      if (bus.gen_start)
        starts++;
      if (bus.gen_valid && bus.gen_ready && bus.gen_done)
        both = 1'b1;
    end
  end

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exv);
    total++;
    assert (obs === exv) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exv);
    end
  endtask

  task automatic chk_q(string tag);
    chk({tag, "_len"}, popq.size(), ex.size());
    for (int i = 0; i < ex.size(); i++) begin
      chk($sformatf("%s_v%0d", tag, i),
          (i < popq.size()) ? popq[i] : -1, ex[i]);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(int a0, int a1, int a2);
    popq.delete();
    pushes     = 0;
    starts     = 0;
    both       = 1'b0;
    bus._start = 1'b1;
    bus.arg0   = a0;
    bus.arg1   = a1;
    bus.arg2   = a2;
    tick();
    bus._start = 1'b0;
  endtask

  bit pv1;
  bit pv2;

  task automatic wait_done(string tag, int lim);
    int n = 0;
    pv1 = 1'b0;
    pv2 = 1'b0;
    while (!bus._done && n < lim) begin
      pv2 = pv1;
      pv1 = bus._valid;
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, bus._done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus._start = 1'b0;
    bus.arg0   = '0;
    bus.arg1   = '0;
    bus.arg2   = '0;
    bus._ready = 1'b0;

    // Reset held with clocks running.
    tick(3);
    chk("rst_gen_reset", bus.gen_reset, 1);
    chk("rst_valid", bus._valid, 0);
    chk("rst_done", bus._done, 0);
    chk("rst_count", bus._count, 0);
    chk("rst_gen_start", bus.gen_start, 0);
    chk("rst_gen_ready", bus.gen_ready, 0);
    chk("rst_out0", bus._out0, 0);
    chk("rst_arg0", bus.gen_arg0, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_gen_reset_hold", bus.gen_reset, 1);
    tick();
    chk("rel_gen_reset_low", bus.gen_reset, 0);
    chk("rel_idle_ready", bus.gen_ready, 0);
    chk("rel_idle_done", bus._done, 0);

    // Basic stream with a free-running sink.
    bus._ready = 1'b1;
    do_start(0, 10, 2);
    wait_done("basic", 50);
    chk("basic_empty_before", pv1, 0);
    chk("basic_valid_2before", pv2, 1);
    ex = '{0, 2, 4, 6, 8};
    chk_q("basic");
    chk("basic_count", bus._count, 5);
    chk("basic_starts", starts, 1);
    chk("basic_arg0", bus.gen_arg0, 0);
    chk("basic_arg1", bus.gen_arg1, 10);
    chk("basic_arg2", bus.gen_arg2, 2);

    // Backpressure: sink stalled for the first 10 cycles.
    bus._ready = 1'b0;
    do_start(0, 10, 2);
    tick(9);
    chk("bp_pushes", pushes, 4);
    chk("bp_gen_ready", bus.gen_ready, 0);
    chk("bp_valid", bus._valid, 1);
    chk("bp_head", bus._out0, 0);
    chk("bp_count", bus._count, 0);
    bus._ready = 1'b1;
    wait_done("bp", 50);
    ex = '{0, 2, 4, 6, 8};
    chk_q("bp");
    chk("bp_count_end", bus._count, 5);

    // Done raised with the last value.
    g_mode = 1'b1;
    do_start(0, 10, 2);
    wait_done("dwd", 50);
    chk("dwd_both", both, 1);
    ex = '{0, 2, 4, 6, 8};
    chk_q("dwd");
    chk("dwd_count", bus._count, 5);
    g_mode = 1'b0;

    // Restart mid-run after two pops.
    bus._ready = 1'b0;
    do_start(0, 20, 2);
    tick(8);
    chk("rs_full", bus.gen_ready, 0);
    bus._ready = 1'b1;
    tick(2);
    bus._ready = 1'b0;
    chk("rs_count_pre", bus._count, 2);
    ex = '{0, 2};
    chk_q("rs_pre");
    do_start(1, 11, 3);
    chk("rs_count_clr", bus._count, 0);
    chk("rs_flushed", bus._valid, 0);
    chk("rs_done_low", bus._done, 0);
    chk("rs_launch_ready", bus.gen_ready, 0);
    bus._ready = 1'b1;
    wait_done("rs", 50);
    ex = '{1, 4, 7, 10};
    chk_q("rs");
    chk("rs_count", bus._count, 4);
    chk("rs_starts", starts, 1);
    chk("rs_arg0", bus.gen_arg0, 1);
    chk("rs_arg1", bus.gen_arg1, 11);
    chk("rs_arg2", bus.gen_arg2, 3);

    // Async reset while draining three entries.
    bus._ready = 1'b0;
    do_start(0, 6, 2);
    tick(10);
    chk("ar_pushes", pushes, 3);
    chk("ar_valid_pre", bus._valid, 1);
    chk("ar_done_pre", bus._done, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", bus._valid, 0);
    chk("ar_done", bus._done, 0);
    chk("ar_gen_reset", bus.gen_reset, 1);
    chk("ar_count", bus._count, 0);
    tick();
    bus._start = 1'b1;
    bus.arg0   = 5;
    bus.arg1   = 5;
    bus.arg2   = 5;
    tick(2);
    bus._start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_rel_gen_reset", bus.gen_reset, 0);
    chk("ar_rel_valid", bus._valid, 0);
    chk("ar_rel_start", bus.gen_start, 0);
    chk("ar_rel_ready", bus.gen_ready, 0);
    chk("ar_rel_arg0", bus.gen_arg0, 0);
    tick(2);
    chk("ar_idle_ready", bus.gen_ready, 0);
    chk("ar_idle_done", bus._done, 0);
    bus._ready = 1'b1;
    do_start(0, 4, 2);
    wait_done("ar_post", 50);
    ex = '{0, 2};
    chk_q("ar_post");
    chk("ar_post_count", bus._count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
